// File: rtl/poly_compress_ctrl.sv
// poly_compress_ctrl
//
// Streams one N-coefficient polynomial from the coefficient RAM through an
// external fixed-latency compress unit. It packs the D-bit results LSB-first
// into a byte stream with a valid/ready handshake, in ByteEncode order.
//
// The compress unit cannot be stalled. Reads are therefore issued only while
// there is guaranteed room for the result. "Room" means that the tags still in
// flight plus the entries already in the coefficient FIFO stay below
// FIFO_DEPTH. This way, downstream backpressure can never lose a coefficient.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         begin one polynomial (sampled only in IDLE)
//   busy          high while a polynomial is in progress (including DONE)
//   done          one-cycle pulse after the final byte is accepted
//   mem_rd_en     RAM read strobe
//   mem_addr      coefficient index
//   mem_rd_data   RAM data, valid MEM_LAT cycles after mem_rd_en
//   cmp_in        to the compress unit (pass-through of mem_rd_data)
//   cmp_out       from the compress unit, CMP_LAT cycles after cmp_in
//   byte_data     packed output byte
//   byte_valid    byte_data valid
//   byte_ready    downstream accept
//   byte_last     high with the final byte of the polynomial
module poly_compress_ctrl #(
   parameter int D          = 4,
   parameter int N          = 256,
   parameter int MEM_LAT    = 1,
   parameter int CMP_LAT    = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_rd_en,
   output logic [$clog2(N)-1:0] mem_addr,
   input  logic [11:0]          mem_rd_data,
   output logic [11:0]          cmp_in,
   input  logic [D-1:0]         cmp_out,
   output logic [7:0]           byte_data,
   output logic                 byte_valid,
   input  logic                 byte_ready,
   output logic                 byte_last
);

   localparam int ADDR_W   = $clog2(N);
   localparam int PIPE_LEN = MEM_LAT + CMP_LAT;
   localparam int N_BYTES  = (N * D) / 8;
   localparam int BCNT_W   = $clog2(N_BYTES + 1);
   localparam int ACC_W    = 8 + D - 1;
   localparam int ACNT_W   = $clog2(ACC_W + 1);
   localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W   = $clog2(FIFO_DEPTH + 1);
   localparam int CREDIT_W = $clog2(FIFO_DEPTH + PIPE_LEN + 1) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [PIPE_LEN-1:0] vpipe_q, vpipe_d;

   logic [D-1:0]        fifo_mem_q [FIFO_DEPTH];
   logic [D-1:0]        fifo_mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [FCNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;

   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACNT_W-1:0]   acc_cnt_q, acc_cnt_d;
   logic [7:0]          byte_data_q, byte_data_d;
   logic                byte_valid_q, byte_valid_d;
   logic                byte_last_q, byte_last_d;
   logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;

   logic [CREDIT_W-1:0] inflight;
   logic                has_credit;
   logic                fifo_push;
   logic                fifo_pop;
   logic                emit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Tags in the valid pipe are reads whose results have not reached the FIFO
   // yet. Counting them as already occupying a FIFO slot is what makes the
   // non-stallable compress unit safe under backpressure.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_LEN; i++) begin
         inflight = inflight + CREDIT_W'(vpipe_q[i]);
      end
      has_credit = (inflight + CREDIT_W'(fifo_cnt_q)) < CREDIT_W'(FIFO_DEPTH);
   end

   // Sequencer.
   // The address counter stops at N-1: the cycle that issues the final read
   // also moves the FSM to DRAIN, so no read beyond the polynomial is issued.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      mem_rd_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               addr_d  = '0;
            end
         end
         ISSUE: begin
            if (has_credit) begin
               mem_rd_en = 1'b1;
               if (addr_q == ADDR_W'(N - 1)) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (byte_valid_q && byte_ready && byte_last_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            addr_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // The valid pipe mirrors the RAM + compress latency. Its output marks the
   // cycle in which cmp_out belongs to an issued read.
   always_comb begin
      vpipe_d = (vpipe_q << 1) | PIPE_LEN'(mem_rd_en);
   end

   // Packer: one action per cycle.
   // Emitting a byte has priority over pulling a coefficient. A pop is only
   // allowed while fewer than 8 bits are buffered, so the accumulator never
   // needs more than 8+D-1 bits.
   always_comb begin
      acc_d        = acc_q;
      acc_cnt_d    = acc_cnt_q;
      byte_data_d  = byte_data_q;
      byte_valid_d = byte_valid_q;
      byte_last_d  = byte_last_q;
      byte_cnt_d   = byte_cnt_q;
      fifo_pop     = 1'b0;
      emit         = (acc_cnt_q >= ACNT_W'(8)) && (!byte_valid_q || byte_ready);
      if (emit) begin
         byte_data_d  = acc_q[7:0];
         acc_d        = acc_q >> 8;
         acc_cnt_d    = acc_cnt_q - ACNT_W'(8);
         byte_valid_d = 1'b1;
         byte_last_d  = (byte_cnt_q == BCNT_W'(N_BYTES - 1));
         byte_cnt_d   = byte_cnt_q + 1'b1;
      end else begin
         if ((acc_cnt_q < ACNT_W'(8)) && (fifo_cnt_q != '0)) begin
            fifo_pop  = 1'b1;
            acc_d     = acc_q | (ACC_W'(fifo_mem_q[rd_ptr_q]) << acc_cnt_q);
            acc_cnt_d = acc_cnt_q + ACNT_W'(D);
         end
         if (byte_valid_q && byte_ready) begin
            byte_valid_d = 1'b0;
            byte_last_d  = 1'b0;
         end
      end
      if (state_q == DONE) begin
         byte_cnt_d = '0;
      end
   end

   // Coefficient FIFO.
   // Pop looks only at the registered count, so an entry pushed into an empty
   // FIFO becomes visible to the packer one cycle later.
   always_comb begin
      fifo_push  = vpipe_q[PIPE_LEN-1];
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (fifo_push) begin
         fifo_mem_d[wr_ptr_q] = cmp_out;
         wr_ptr_d             = ptr_inc(wr_ptr_q);
      end
      if (fifo_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
   end

   // State register.
   // Reset clears everything at once, so an aborted polynomial leaves no
   // residue in the tag pipe, the FIFO or the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         vpipe_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
         acc_q        <= '0;
         acc_cnt_q    <= '0;
         byte_data_q  <= '0;
         byte_valid_q <= 1'b0;
         byte_last_q  <= 1'b0;
         byte_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         vpipe_q      <= vpipe_d;
         fifo_mem_q   <= fifo_mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         fifo_cnt_q   <= fifo_cnt_d;
         acc_q        <= acc_d;
         acc_cnt_q    <= acc_cnt_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         byte_last_q  <= byte_last_d;
         byte_cnt_q   <= byte_cnt_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign mem_addr   = addr_q;
   assign cmp_in     = mem_rd_data;
   assign byte_data  = byte_data_q;
   assign byte_valid = byte_valid_q;
   assign byte_last  = byte_last_q;

   // The credit rule must keep the FIFO from overflowing.
   // A finished polynomial must leave nothing behind.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(fifo_push && !fifo_pop && (fifo_cnt_q == FCNT_W'(FIFO_DEPTH))));

   a_clean_done: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == DONE) |-> ((acc_cnt_q == '0) && (fifo_cnt_q == '0) && (inflight == '0)));

endmodule

// File: tb/tb_poly_compress_ctrl.sv
// Testbench for poly_compress_ctrl.
//
// Three instances (D=4, D=10, D=1) share one RAM model and one clock. Each
// instance has its own compress-unit model. The compress model computes
// round(2^d * x / 3329) mod 2^d. Expected bytes are rebuilt bit by bit from
// the RAM contents.
module tb_poly_compress_ctrl;

   localparam int N = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic [11:0] ram [N];

   int checkCount = 0;
   int passCount  = 0;

   logic       start4 = 1'b0, busy4, done4, rdEn4, valid4, last4;
   logic       ready4 = 1'b1;
   logic [7:0] addr4, byte4;
   logic [11:0] rdData4, cmpIn4;
   logic [3:0] cmpOut4;
   logic [3:0] cmpPipe4 [3];

   logic       start10 = 1'b0, busy10, done10, rdEn10, valid10, last10;
   logic       ready10 = 1'b1;
   logic [7:0] addr10, byte10;
   logic [11:0] rdData10, cmpIn10;
   logic [9:0] cmpOut10;
   logic [9:0] cmpPipe10 [3];

   logic       start1 = 1'b0, busy1, done1, rdEn1, valid1, last1;
   logic       ready1 = 1'b1;
   logic [7:0] addr1, byte1;
   logic [11:0] rdData1, cmpIn1;
   logic [0:0] cmpOut1;
   logic [0:0] cmpPipe1 [3];

   logic hold4 = 1'b0;
   logic randReady10 = 1'b0;
   logic clearMon = 1'b0;

   logic [7:0] got4[$];
   logic [7:0] got10[$];
   logic [7:0] got1[$];
   int lastCnt [3];
   int lastPos [3];
   int doneCnt [3];
   int rdCnt [3];

   // The free-running clock for all three instances.
   always #5 clk = ~clk;

   poly_compress_ctrl #(.D(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
      .mem_rd_en(rdEn4), .mem_addr(addr4), .mem_rd_data(rdData4),
      .cmp_in(cmpIn4), .cmp_out(cmpOut4), .byte_data(byte4),
      .byte_valid(valid4), .byte_ready(ready4), .byte_last(last4)
   );

   poly_compress_ctrl #(.D(10)) dut10 (
      .clk(clk), .rst_n(rst_n), .start(start10), .busy(busy10), .done(done10),
      .mem_rd_en(rdEn10), .mem_addr(addr10), .mem_rd_data(rdData10),
      .cmp_in(cmpIn10), .cmp_out(cmpOut10), .byte_data(byte10),
      .byte_valid(valid10), .byte_ready(ready10), .byte_last(last10)
   );

   poly_compress_ctrl #(.D(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .mem_rd_en(rdEn1), .mem_addr(addr1), .mem_rd_data(rdData1),
      .cmp_in(cmpIn1), .cmp_out(cmpOut1), .byte_data(byte1),
      .byte_valid(valid1), .byte_ready(ready1), .byte_last(last1)
   );

   function automatic int compress(input int x, input int d);
      return (((x << d) + 1664) / 3329) % (1 << d);
   endfunction

   function automatic logic [7:0] goldenByte(input int k, input int d);
      logic [7:0] b;
      int bitIdx;
      int coef;
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
         bitIdx = k * 8 + j;
         coef = compress(int'(ram[bitIdx / d]), d);
         b[j] = coef[bitIdx % d];
      end
      return b;
   endfunction

   // RAM models with one cycle of read latency, followed by three-stage
   // compress pipelines. Together these give the MEM_LAT=1 / CMP_LAT=3
   // timing that the controller's tag pipe expects.
   always_ff @(posedge clk) begin
      if (rdEn4) rdData4 <= ram[addr4];
      if (rdEn10) rdData10 <= ram[addr10];
      if (rdEn1) rdData1 <= ram[addr1];
      cmpPipe4[0] <= 4'(compress(int'(cmpIn4), 4));
      cmpPipe4[1] <= cmpPipe4[0];
      cmpPipe4[2] <= cmpPipe4[1];
      cmpPipe10[0] <= 10'(compress(int'(cmpIn10), 10));
      cmpPipe10[1] <= cmpPipe10[0];
      cmpPipe10[2] <= cmpPipe10[1];
      cmpPipe1[0] <= 1'(compress(int'(cmpIn1), 1));
      cmpPipe1[1] <= cmpPipe1[0];
      cmpPipe1[2] <= cmpPipe1[1];
   end

   assign cmpOut4  = cmpPipe4[2];
   assign cmpOut10 = cmpPipe10[2];
   assign cmpOut1  = cmpPipe1[2];

   // Downstream ready is driven just after each rising edge. Instance 4 can
   // be held off to create backpressure. Instance 10 can be randomised.
   always @(posedge clk) begin
      #1;
      ready4  = !hold4;
      ready10 = randReady10 ? 1'($urandom_range(0, 1)) : 1'b1;
      ready1  = 1'b1;
   end

   // Output monitor, sampled on the falling edge. It records every accepted
   // byte, where byte_last appeared, done pulses and issued reads.
   always @(negedge clk) begin
      if (clearMon) begin
         got4.delete();
         got10.delete();
         got1.delete();
         for (int s = 0; s < 3; s++) begin
            lastCnt[s] = 0;
            lastPos[s] = -1;
            doneCnt[s] = 0;
            rdCnt[s]   = 0;
         end
      end else if (rst_n) begin
         if (valid4 && ready4) begin
            if (last4) begin lastCnt[0]++; lastPos[0] = got4.size(); end
            got4.push_back(byte4);
         end
         if (valid10 && ready10) begin
            if (last10) begin lastCnt[1]++; lastPos[1] = got10.size(); end
            got10.push_back(byte10);
         end
         if (valid1 && ready1) begin
            if (last1) begin lastCnt[2]++; lastPos[2] = got1.size(); end
            got1.push_back(byte1);
         end
         if (done4) doneCnt[0]++;
         if (done10) doneCnt[1]++;
         if (done1) doneCnt[2]++;
         if (rdEn4) rdCnt[0]++;
         if (rdEn10) rdCnt[1]++;
         if (rdEn1) rdCnt[2]++;
      end
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checkCount++;
      if (observed == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic resetMonitors();
      @(negedge clk);
      #1 clearMon = 1'b1;
      @(negedge clk);
      #1 clearMon = 1'b0;
   endtask

   task automatic applyStimulus(input int slot);
      @(negedge clk);
      #1;
      case (slot)
         0: start4 = 1'b1;
         1: start10 = 1'b1;
         default: start1 = 1'b1;
      endcase
      @(negedge clk);
      #1;
      start4  = 1'b0;
      start10 = 1'b0;
      start1  = 1'b0;
   endtask

   task automatic waitForDone(input int slot, input string tag);
      int  cycles;
      logic seen;
      logic b;
      logic d;
      cycles = 0;
      seen = 1'b0;
      while (!seen && cycles < 5000) begin
         @(negedge clk);
         cycles++;
         case (slot)
            0: seen = done4;
            1: seen = done10;
            default: seen = done1;
         endcase
      end
      checkOutput({tag, " done seen"}, longint'(seen), 1);
      @(negedge clk);
      case (slot)
         0: begin b = busy4; d = done4; end
         1: begin b = busy10; d = done10; end
         default: begin b = busy1; d = done1; end
      endcase
      checkOutput({tag, " busy after done"}, longint'(b), 0);
      checkOutput({tag, " done one cycle"}, longint'(d), 0);
   endtask

   task automatic waitForBytes(input int slot, input int count, input string tag);
      int cycles;
      int have;
      cycles = 0;
      have = 0;
      while (have < count && cycles < 5000) begin
         @(negedge clk);
         cycles++;
         case (slot)
            0: have = got4.size();
            1: have = got10.size();
            default: have = got1.size();
         endcase
      end
      checkOutput({tag, " bytes reached"}, longint'(have >= count), 1);
   endtask

   task automatic checkStream(input int slot, input int nBytes, input int d, input string tag);
      logic [7:0] got[$];
      int bad;
      int firstBad;
      bad = 0;
      firstBad = -1;
      case (slot)
         0: got = got4;
         1: got = got10;
         default: got = got1;
      endcase
      checkOutput({tag, " byte count"}, got.size(), nBytes);
      for (int k = 0; k < got.size() && k < nBytes; k++) begin
         if (got[k] !== goldenByte(k, d)) begin
            bad++;
            if (firstBad < 0) firstBad = k;
         end
      end
      if (bad != 0) begin
         $display("[TB] %s first differing byte index %0d", tag, firstBad);
      end
      checkOutput({tag, " wrong bytes"}, bad, 0);
      checkOutput({tag, " last count"}, lastCnt[slot], 1);
      checkOutput({tag, " last position"}, lastPos[slot], nBytes - 1);
      checkOutput({tag, " done pulses"}, doneCnt[slot], 1);
   endtask

   // Main sequence: reset, the directed D=4 cases, then D=10 and D=1.
   initial begin
      logic [7:0] b0;
      logic [7:0] q0;
      logic [7:0] q1;
      int unstable;
      int seenValid;
      int notFF;

      for (int i = 0; i < N; i++) ram[i] = 12'd0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset busy", busy4, 0);
      checkOutput("reset done", done4, 0);
      checkOutput("reset mem_rd_en", rdEn4, 0);
      checkOutput("reset mem_addr", addr4, 0);
      checkOutput("reset byte_valid", valid4, 0);
      checkOutput("reset byte_data", byte4, 0);
      checkOutput("reset byte_last", last4, 0);
      #1 rst_n = 1'b1;

      $display("[TB] A: directed coefficients, D=4");
      ram[0] = 12'd209;
      ram[1] = 12'd1665;
      ram[2] = 12'd3328;
      ram[3] = 12'd0;
      resetMonitors();
      applyStimulus(0);
      checkOutput("A busy after start", busy4, 1);
      waitForDone(0, "A");
      repeat (5) @(negedge clk);
      q0 = (got4.size() > 1) ? got4[0] : 8'h5A;
      q1 = (got4.size() > 1) ? got4[1] : 8'h5A;
      checkOutput("A byte0", q0, 8'h81);
      checkOutput("A byte1", q1, 8'h00);
      checkStream(0, 128, 4, "A");

      $display("[TB] B: backpressure, D=4");
      for (int i = 0; i < N; i++) ram[i] = 12'($urandom_range(0, 3328));
      hold4 = 1'b1;
      resetMonitors();
      applyStimulus(0);
      seenValid = 0;
      for (int c = 0; c < 200 && seenValid == 0; c++) begin
         @(negedge clk);
         if (valid4) seenValid = 1;
      end
      checkOutput("B first valid", seenValid, 1);
      b0 = byte4;
      unstable = 0;
      repeat (40) begin
         @(negedge clk);
         if (byte4 !== b0 || valid4 !== 1'b1) unstable++;
      end
      checkOutput("B byte0 value", b0, goldenByte(0, 4));
      checkOutput("B byte0 held", unstable, 0);
      checkOutput("B reads during stall", rdCnt[0], 12);
      hold4 = 1'b0;
      waitForDone(0, "B");
      repeat (5) @(negedge clk);
      checkStream(0, 128, 4, "B");

      $display("[TB] C: start while busy, D=4");
      for (int i = 0; i < N; i++) ram[i] = 12'($urandom_range(0, 3328));
      resetMonitors();
      applyStimulus(0);
      repeat (3) @(negedge clk);
      applyStimulus(0);
      waitForBytes(0, 60, "C");
      applyStimulus(0);
      waitForDone(0, "C");
      repeat (20) @(negedge clk);
      checkOutput("C idle after done", busy4, 0);
      checkStream(0, 128, 4, "C");

      $display("[TB] D: reset mid-stream, D=4");
      for (int i = 0; i < N; i++) ram[i] = 12'($urandom_range(0, 3328));
      resetMonitors();
      applyStimulus(0);
      waitForBytes(0, 50, "D");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("D reset busy", busy4, 0);
      checkOutput("D reset done", done4, 0);
      checkOutput("D reset mem_rd_en", rdEn4, 0);
      checkOutput("D reset mem_addr", addr4, 0);
      checkOutput("D reset byte_valid", valid4, 0);
      checkOutput("D reset byte_data", byte4, 0);
      checkOutput("D reset byte_last", last4, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      resetMonitors();
      repeat (10) @(negedge clk);
      checkOutput("D no bytes after reset", got4.size(), 0);
      checkOutput("D no reads after reset", rdCnt[0], 0);
      applyStimulus(0);
      waitForDone(0, "D");
      repeat (5) @(negedge clk);
      checkStream(0, 128, 4, "D");

      $display("[TB] E: random coefficients and ready, D=10");
      for (int i = 0; i < N; i++) ram[i] = 12'($urandom_range(0, 3328));
      randReady10 = 1'b1;
      resetMonitors();
      applyStimulus(1);
      waitForDone(1, "E");
      randReady10 = 1'b0;
      repeat (5) @(negedge clk);
      checkStream(1, 320, 10, "E");

      $display("[TB] F: all 1665, D=1");
      for (int i = 0; i < N; i++) ram[i] = 12'd1665;
      resetMonitors();
      applyStimulus(2);
      waitForDone(2, "F");
      repeat (5) @(negedge clk);
      notFF = 0;
      foreach (got1[k]) if (got1[k] !== 8'hFF) notFF++;
      checkOutput("F non-FF bytes", notFF, 0);
      checkStream(2, 32, 1, "F");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/poly_compress_ctrl.md
Name: poly_compress_ctrl

Overview:
- Sequencer that streams one 256-coefficient polynomial from coefficient RAM through a fixed-latency compress unit.
- Packs the D-bit results LSB-first into a byte stream with a valid/ready handshake, in Kyber ByteEncode order.
- Sits between the polynomial RAM and the ciphertext serializer.
- The compress unit has no enable, so the block uses credit-based issue to tolerate downstream backpressure.

Parameters:
- D, 4: compressed width per coefficient. Legal values are 1, 4, 5, 10, 11, so N*D is always a multiple of 8.
- N, 256: coefficients per polynomial.
- MEM_LAT, 1: RAM read latency, in cycles from mem_rd_en to mem_rd_data.
- CMP_LAT, 3: compress latency, in cycles from cmp_in to cmp_out.
- FIFO_DEPTH, 8: coefficient FIFO entries. Must be ≥ MEM_LAT+CMP_LAT+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin one polynomial; sampled only in IDLE
- busy  out  1  high while a polynomial is in progress
- done  out  1  one-cycle pulse after the final byte is accepted
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  $clog2(N)  coefficient index
- mem_rd_data  in  12  coefficient, valid MEM_LAT cycles after mem_rd_en
- cmp_in  out  12  to compress unit; combinational pass-through of mem_rd_data
- cmp_out  in  D  from compress unit
- byte_data  out  8  packed output byte
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  downstream accept
- byte_last  out  1  high with the final byte of the polynomial

Behaviour:
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, byte_valid=0, byte_data=0, byte_last=0. FSM=IDLE; all counters, tag pipe, FIFO and accumulator cleared.
- Reset mid-operation aborts immediately. No partial bytes are emitted after reset is released.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE→ISSUE on start=1. busy goes high the following cycle.
  - ISSUE→DRAIN in the cycle the read for address N-1 is issued.
  - DRAIN→DONE when byte_valid&byte_ready&byte_last.
  - DONE→IDLE unconditionally after one cycle. done=1 only in DONE; busy stays 1 in DONE.
- start is ignored outside IDLE.
- Issue rule: in ISSUE, mem_rd_en=1 iff inflight+fifo_count < FIFO_DEPTH. Here inflight = number of tags in the valid pipe.
  - mem_addr increments by 1 after each issued read, starting at 0 and ending at N-1.
  - No wrap: the counter is not advanced past N-1.
- Valid pipe: a shift register of MEM_LAT+CMP_LAT stages carries mem_rd_en.
  - When its output is 1, cmp_out is pushed into the FIFO that cycle.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- Packer: bit accumulator acc (≥ 8+D-1 bits) with acc_cnt. One action per cycle, in priority order:
  1. Emit: if acc_cnt≥8 and (byte_valid=0 or byte_ready=1), then byte_data←acc[7:0], acc>>=8, acc_cnt-=8, byte_valid←1.
  2. Pop: else if acc_cnt<8 and the FIFO is not empty, pop one entry v, acc|=v<<acc_cnt, acc_cnt+=D.
  3. Clear: if byte_valid&byte_ready and no emit occurs, byte_valid←0.
- Byte counting: bytes numbered 0..N*D/8-1. byte_last=1 with byte N*D/8-1.
- Handshake: byte_data and byte_last are held stable while byte_valid=1 and byte_ready=0.
- FIFO push and pop in the same cycle: count unchanged. Push into an empty FIFO is not poppable until the next cycle (registered).
- Coefficient order is preserved. Coefficient i occupies stream bits [i*D +: D], LSB-first within each byte.
- mem_rd_data/cmp_in content is don't-care on cycles with no tag.
- After done, acc_cnt=0, the FIFO is empty and no tags are in flight. This is asserted.

Test Plan:
- D=4, real compress unit, RAM c[0]=209, c[1]=1665, c[2]=3328, c[3]=0, rest 0, byte_ready=1 → byte0=0x81, byte1=0x00, 128 bytes total, byte_last on byte 127, done pulses once, busy low the next cycle.
- D=4, byte_ready held 0 for 40 cycles after the first byte_valid → at most FIFO_DEPTH reads outstanding, byte0 stable, then a full stream matching the golden model with no loss or duplication.
- D=10, random coefficients 0..3328, byte_ready random 50% → 320 bytes equal to the software ByteEncode10(Compress10(c)).
- start pulsed again while busy, mid-stream → ignored; exactly one done and 128 bytes (D=4).
- rst_n asserted at byte 50 of 128 → all outputs at reset values immediately. A new start then produces a correct full 128-byte stream.
- D=1, all c=1665 → every coefficient compresses to 1, so 32 bytes of 0xFF.
